// File: rtl/cci_mpf_tx_chan_buf.sv
// ---------------------------------------------------------------------------
// cci_mpf_tx_chan_buf
//
// Per-channel elastic buffer between an AFU request source and the FIU.
// Each of the N_CHAN channels owns a private FIFO, pointer pair, occupancy
// counter and sticky overflow flag. Channels never interact.
//
// The AFU pushes whenever afu_tx_valid[i] is high. It is told to slow down
// through afu_tx_alm_full[i], which is decoded from the registered occupancy.
// Entries drain toward the FIU one per cycle while fiu_tx_alm_full[i] is low.
// fiu_tx_valid/fiu_tx_data are registered, so an entry pushed at one edge can
// appear at the FIU after the following edge at the earliest.
//
// Ports
//   clk               sole clock, rising edge
//   reset             asynchronous, active-high reset
//   afu_tx_valid      [N_CHAN]             per-channel push request
//   afu_tx_data       [N_CHAN*DATA_WIDTH]  payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   afu_tx_alm_full   [N_CHAN]             occupancy >= DEPTH - ALM_FULL_SLACK
//   fiu_tx_alm_full   [N_CHAN]             FIU back-pressure, blocks pops
//   fiu_tx_valid      [N_CHAN]             registered request valid toward FIU
//   fiu_tx_data       [N_CHAN*DATA_WIDTH]  registered payloads toward FIU
//   occupancy         [N_CHAN*CW]          registered entry count per channel
//   overflow          [N_CHAN]             sticky: a push was dropped while full
// ---------------------------------------------------------------------------
module cci_mpf_tx_chan_buf #(
  parameter int N_CHAN         = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 8,
  parameter int ALM_FULL_SLACK = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CHAN-1:0]                      afu_tx_valid,
  input  logic [N_CHAN*DATA_WIDTH-1:0]           afu_tx_data,
  output logic [N_CHAN-1:0]                      afu_tx_alm_full,
  input  logic [N_CHAN-1:0]                      fiu_tx_alm_full,
  output logic [N_CHAN-1:0]                      fiu_tx_valid,
  output logic [N_CHAN*DATA_WIDTH-1:0]           fiu_tx_data,
  output logic [N_CHAN*($clog2(DEPTH)+1)-1:0]    occupancy,
  output logic [N_CHAN-1:0]                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ALM_COUNT  = CW'(DEPTH - ALM_FULL_SLACK);

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  ovf;
    logic                  pop;
    logic                  push_ok;
    logic                  push_drop;

    // Pop and push decisions look only at the count before this edge, so an
    // entry written at this edge can never be popped at the same edge. A pop
    // at the same edge frees a slot, which lets a push into a full FIFO land.
    assign pop       = (count != '0) && !fiu_tx_alm_full[i];
    assign push_ok   = afu_tx_valid[i] && ((count != FULL_COUNT) || pop);
    assign push_drop = afu_tx_valid[i] && !push_ok;

    // Payload storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= afu_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // Control state and the registered FIU-side outputs. Pointers are exactly
    // log2(DEPTH) bits wide, so incrementing past the end wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        ovf       <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          out_data <= mem[rd_ptr];
        end
        out_valid <= pop;
        if (push_ok && !pop) begin
          count <= count + 1'b1;
        end else if (!push_ok && pop) begin
          count <= count - 1'b1;
        end
        if (push_drop) begin
          ovf <= 1'b1;
        end
      end
    end

    assign fiu_tx_valid[i]                         = out_valid;
    assign fiu_tx_data[i*DATA_WIDTH +: DATA_WIDTH] = out_data;
    assign occupancy[i*CW +: CW]                   = count;
    assign overflow[i]                             = ovf;
    // Decoded purely from the count register: no path from any input.
    assign afu_tx_alm_full[i]                      = (count >= ALM_COUNT);

  end

endmodule

// File: tb/tb_cci_mpf_tx_chan_buf.sv
// ---------------------------------------------------------------------------
// tb_cci_mpf_tx_chan_buf
//
// Drives the buffer with directed scenarios followed by random traffic and
// compares every output after every edge against a queue-based reference
// model of the per-channel FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_cci_mpf_tx_chan_buf;

  localparam int NC    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SLACK = 3;
  localparam int CW    = 4;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     afu_tx_valid;
  logic [NC*DW-1:0]  afu_tx_data;
  logic [NC-1:0]     fiu_tx_alm_full;
  wire  [NC-1:0]     afu_tx_alm_full;
  wire  [NC-1:0]     fiu_tx_valid;
  wire  [NC*DW-1:0]  fiu_tx_data;
  wire  [NC*CW-1:0]  occupancy;
  wire  [NC-1:0]     overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the expected output registers.
  logic [DW-1:0] mq [NC][$];
  logic [NC-1:0] exp_valid;
  logic [NC-1:0] exp_ovf;
  logic [DW-1:0] exp_data [NC];

  cci_mpf_tx_chan_buf #(
    .N_CHAN(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALM_FULL_SLACK(SLACK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .afu_tx_valid    (afu_tx_valid),
    .afu_tx_data     (afu_tx_data),
    .afu_tx_alm_full (afu_tx_alm_full),
    .fiu_tx_alm_full (fiu_tx_alm_full),
    .fiu_tx_valid    (fiu_tx_valid),
    .fiu_tx_data     (fiu_tx_data),
    .occupancy       (occupancy),
    .overflow        (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int ch = 0; ch < NC; ch++) begin
      check($sformatf("%s.valid%0d", tag, ch), 32'(fiu_tx_valid[ch]), 32'(exp_valid[ch]));
      check($sformatf("%s.data%0d", tag, ch), 32'(fiu_tx_data[ch*DW +: DW]), 32'(exp_data[ch]));
      check($sformatf("%s.occ%0d", tag, ch), 32'(occupancy[ch*CW +: CW]), 32'(mq[ch].size()));
      check($sformatf("%s.ovf%0d", tag, ch), 32'(overflow[ch]), 32'(exp_ovf[ch]));
      check($sformatf("%s.almfull%0d", tag, ch), 32'(afu_tx_alm_full[ch]),
            32'(mq[ch].size() >= DEPTH - SLACK));
    end
  endtask

  task automatic clearModel();
    for (int ch = 0; ch < NC; ch++) begin
      mq[ch].delete();
      exp_data[ch] = '0;
    end
    exp_valid = '0;
    exp_ovf   = '0;
  endtask

  // One clock edge of FIFO behaviour: the head leaves if anything was queued
  // before the edge and the FIU is not back-pressuring; a push lands if room
  // remains after that departure, otherwise it is dropped and flagged.
  task automatic modelEdge();
    for (int ch = 0; ch < NC; ch++) begin
      if (mq[ch].size() > 0 && !fiu_tx_alm_full[ch]) begin
        exp_data[ch]  = mq[ch].pop_front();
        exp_valid[ch] = 1'b1;
      end else begin
        exp_valid[ch] = 1'b0;
      end
      if (afu_tx_valid[ch]) begin
        if (mq[ch].size() < DEPTH) mq[ch].push_back(afu_tx_data[ch*DW +: DW]);
        else                       exp_ovf[ch] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [1:0] af,
                               input string tag);
    afu_tx_valid    = v;
    afu_tx_data     = {d1, d0};
    fiu_tx_alm_full = af;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset is raised between edges and checked before the next edge arrives.
  task automatic doReset(input string tag);
    reset           = 1'b1;
    afu_tx_valid    = '0;
    afu_tx_data     = '0;
    fiu_tx_alm_full = '0;
    clearModel();
    #1;
    checkOutput({tag, ".async"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".held"});
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    afu_tx_valid    = '0;
    afu_tx_data     = '0;
    fiu_tx_alm_full = '0;
    clearModel();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_async");
    @(posedge clk);
    #1;
    checkOutput("reset_held");
    #2;
    reset = 1'b0;

    // Single request latency.
    applyStimulus(2'b01, 16'h1234, 16'h0, 2'b00, "lat_push");
    check("lat_not_early", 32'(fiu_tx_valid[0]), 32'd0);
    applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, "lat_pop");
    check("lat_data", 32'(fiu_tx_data[15:0]), 32'h1234);
    check("lat_valid", 32'(fiu_tx_valid[0]), 32'd1);
    applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, "lat_idle");

    // Fill channel 0 past capacity while the FIU stalls.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(2'b01, 16'(k), 16'h0, 2'b01, $sformatf("fill%0d", k));
    end
    check("fill_occ", 32'(occupancy[3:0]), 32'd8);
    check("fill_ovf", 32'(overflow[0]), 32'd1);

    // Drain in order; overflow stays sticky.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, $sformatf("drain%0d", k));
    end
    check("drain_ovf_sticky", 32'(overflow[0]), 32'd1);

    doReset("rst_a");

    // Same-edge push and pop on a full channel.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2'b01, 16'h0100 + 16'(k), 16'h0, 2'b01, $sformatf("full%0d", k));
    end
    applyStimulus(2'b01, 16'h01AA, 16'h0, 2'b00, "pushpop");
    check("pushpop_occ", 32'(occupancy[3:0]), 32'd8);
    check("pushpop_ovf", 32'(overflow[0]), 32'd0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, $sformatf("pp_drain%0d", k));
    end
    check("pushpop_last", 32'(fiu_tx_data[15:0]), 32'h01AA);

    // Channel isolation: ch1 stalled with 3 entries, ch0 streams.
    for (int k = 0; k < 12; k++) begin
      applyStimulus({k < 3, 1'b1}, 16'h3000 + 16'(k), 16'h4000 + 16'(k), 2'b10,
                    $sformatf("iso%0d", k));
    end
    check("iso_ch1_idle", 32'(fiu_tx_valid[1]), 32'd0);
    check("iso_ch0_stream", 32'(fiu_tx_valid[0]), 32'd1);

    doReset("rst_b");

    // Reset with data in flight, then a fresh request comes out first.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 16'h5000 + 16'(k), 16'h6000 + 16'(k), 2'b11, $sformatf("pre%0d", k));
    end
    check("pre_occ1", 32'(occupancy[7:4]), 32'd6);
    doReset("rst_c");
    applyStimulus(2'b01, 16'hBEEF, 16'h0, 2'b00, "beef_push");
    applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, "beef_pop");
    check("beef_data", 32'(fiu_tx_data[15:0]), 32'hBEEF);

    // Random traffic: a congested phase, then a mostly free-flowing phase.
    for (int k = 0; k < 500; k++) begin
      logic [1:0] af;
      for (int ch = 0; ch < NC; ch++) begin
        if (k < 250) af[ch] = ($urandom_range(0, 3) != 0);
        else         af[ch] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), af,
                    $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
